// File: rtl/led_pkg.sv
// Shared constants for the 7-segment scan capture: glyph table, digit count, FSM states.
package led_pkg;

    localparam int NUM_DIGITS = 8;

    // Segment order is gfedcba, segment a in bit 0.
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;

    typedef enum logic {IDLE, COLLECT} state_t;

    function automatic logic [6:0] seg_glyph(input logic [3:0] n);
        case (n)
            4'h0: return SEG_0;
            4'h1: return SEG_1;
            4'h2: return SEG_2;
            4'h3: return SEG_3;
            4'h4: return SEG_4;
            4'h5: return SEG_5;
            4'h6: return SEG_6;
            4'h7: return SEG_7;
            4'h8: return SEG_8;
            4'h9: return SEG_9;
            4'hA: return SEG_A;
            4'hB: return SEG_B;
            4'hC: return SEG_C;
            4'hD: return SEG_D;
            4'hE: return SEG_E;
            default: return SEG_F;
        endcase
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational reverse lookup of a lit-high segment pattern to a hex nibble.
module seg7_decode
    import led_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       blank,
    output logic       invalid
);

    always_comb begin
        nibble  = 4'h0;
        blank   = (seg == SEG_BLANK);
        invalid = (seg != SEG_BLANK);
        for (int i = 0; i < 16; i++) begin
            if (seg == seg_glyph(4'(i))) begin
                nibble  = 4'(i);
                invalid = 1'b0;
            end
        end
    end

endmodule

// File: rtl/led_scan_capture.sv
// Monitors a multiplexed 8-digit 7-segment scan and rebuilds whole frames,
// flagging out-of-order digits, multi-hot enables, unknown glyphs and stalls.
module led_scan_capture
    import led_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit EN_ACTIVE_LOW  = 1'b1,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [7:0]  seg,
    input  logic [7:0]  dig_en,
    output logic        frame_valid,
    output logic [31:0] frame_data,
    output logic [7:0]  frame_dp,
    output logic [7:0]  frame_blank,
    output logic        scan_err,
    output logic        onehot_err,
    output logic        decode_err,
    output logic        stalled
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TOUT_MAX   = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TOUT_LAST  = TW'(TIMEOUT_CYCLES - 1);

    logic [7:0]    seg_q, en_q, en_d;
    logic [SW-1:0] settle_cnt, settle_nxt;
    logic          taken;
    logic          stable, fire, multi_hot, good;
    logic [2:0]    digit;
    logic [3:0]    dec_nib;
    logic          dec_blank, dec_inv;
    logic [TW-1:0] tout_cnt;
    logic          stall_hit;

    state_t        state, state_nxt;
    logic [2:0]    exp_dig, exp_nxt;
    logic          store, frame_done, scan_hit;

    logic [NUM_DIGITS-1:0][3:0] nib_buf;
    logic [NUM_DIGITS-1:0]      dp_buf, blank_buf;

    // Internal form: 1 = lit segment / selected digit.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            seg_q <= '0;
            en_q  <= '0;
            en_d  <= '0;
        end else begin
            seg_q <= SEG_ACTIVE_LOW ? ~seg : seg;
            en_q  <= EN_ACTIVE_LOW ? ~dig_en : dig_en;
            en_d  <= en_q;
        end
    end

    assign stable    = (en_q == en_d) && (en_q != 8'h00);
    assign multi_hot = (en_q & (en_q - 8'd1)) != 8'h00;

    always_comb begin
        settle_nxt = '0;
        if (stable)
            settle_nxt = (settle_cnt == SETTLE_MAX) ? settle_cnt : settle_cnt + SW'(1);
    end

    // 'taken' blocks a second sample until the enable pattern changes.
    assign fire = stable && !taken && (settle_nxt == SETTLE_MAX);
    assign good = fire && !multi_hot;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            settle_cnt <= '0;
            taken      <= 1'b0;
        end else begin
            settle_cnt <= settle_nxt;
            taken      <= stable && (taken || fire);
        end
    end

    always_comb begin
        digit = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (en_q[i]) digit = 3'(i);
    end

    seg7_decode u_dec (
        .seg     (seg_q[6:0]),
        .nibble  (dec_nib),
        .blank   (dec_blank),
        .invalid (dec_inv)
    );

    // Only a usable (one-hot) sample counts as activity for the stall timer.
    assign stall_hit = !good && (tout_cnt == TOUT_LAST);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            tout_cnt <= '0;
            stalled  <= 1'b0;
        end else if (good) begin
            tout_cnt <= '0;
            stalled  <= 1'b0;
        end else begin
            if (tout_cnt != TOUT_MAX) tout_cnt <= tout_cnt + TW'(1);
            if (stall_hit) stalled <= 1'b1;
        end
    end

    always_comb begin
        state_nxt  = state;
        exp_nxt    = exp_dig;
        store      = 1'b0;
        frame_done = 1'b0;
        scan_hit   = 1'b0;
        if (good) begin
            if (state == IDLE || exp_dig == 3'd0) begin
                if (digit == 3'd0) begin
                    store     = 1'b1;
                    exp_nxt   = 3'd1;
                    state_nxt = COLLECT;
                end else if (state == COLLECT) begin
                    scan_hit  = 1'b1;
                    exp_nxt   = 3'd0;
                    state_nxt = IDLE;
                end
            end else if (digit == exp_dig) begin
                store      = 1'b1;
                exp_nxt    = exp_dig + 3'd1;
                frame_done = (digit == 3'd7);
            end else begin
                scan_hit = 1'b1;
                if (digit == 3'd0) begin
                    store   = 1'b1;
                    exp_nxt = 3'd1;
                end else begin
                    exp_nxt   = 3'd0;
                    state_nxt = IDLE;
                end
            end
        end else if (stall_hit) begin
            exp_nxt   = 3'd0;
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            exp_dig   <= 3'd0;
            nib_buf   <= '0;
            dp_buf    <= '0;
            blank_buf <= '0;
        end else begin
            state   <= state_nxt;
            exp_dig <= exp_nxt;
            if (store) begin
                nib_buf[digit]   <= dec_nib;
                dp_buf[digit]    <= seg_q[7];
                blank_buf[digit] <= dec_blank;
            end
        end
    end

    // Digit 7 is still being written into the buffer, so it is taken straight from the decoder.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            frame_valid <= 1'b0;
            frame_data  <= '0;
            frame_dp    <= '0;
            frame_blank <= '0;
            scan_err    <= 1'b0;
            onehot_err  <= 1'b0;
            decode_err  <= 1'b0;
        end else begin
            frame_valid <= frame_done;
            scan_err    <= scan_hit;
            onehot_err  <= fire && multi_hot;
            decode_err  <= good && dec_inv;
            if (frame_done) begin
                frame_data  <= {dec_nib, nib_buf[6:0]};
                frame_dp    <= {seg_q[7], dp_buf[6:0]};
                frame_blank <= {dec_blank, blank_buf[6:0]};
            end
        end
    end

endmodule

// File: tb/tb_led_scan_capture.sv
// Randomised and directed bench for led_scan_capture against a run-length / queue model.
module tb_led_scan_capture;

    localparam int SETTLE = 4;
    localparam int TOUT   = 4096;
    localparam int NEED   = (SETTLE > 1) ? SETTLE : 2;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [7:0]  seg = 8'hFF;
    logic [7:0]  dig_en = 8'hFF;
    logic        frame_valid, scan_err, onehot_err, decode_err, stalled;
    logic [31:0] frame_data;
    logic [7:0]  frame_dp, frame_blank;

    int checks = 0;
    int failures = 0;
    int dut_frames = 0, dut_se = 0, dut_oe = 0, dut_de = 0;

    led_scan_capture #(
        .SEG_ACTIVE_LOW (1'b1),
        .EN_ACTIVE_LOW  (1'b1),
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .seg         (seg),
        .dig_en      (dig_en),
        .frame_valid (frame_valid),
        .frame_data  (frame_data),
        .frame_dp    (frame_dp),
        .frame_blank (frame_blank),
        .scan_err    (scan_err),
        .onehot_err  (onehot_err),
        .decode_err  (decode_err),
        .stalled     (stalled)
    );

    always #5 clk = ~clk;

    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Model: history of what the sampling register saw, plus a list of digits collected so far.
    logic [7:0]  h_en, h_seg;
    int          same_len, n_col, stall_cnt;
    bit          armed;
    logic [3:0]  m_nib [8];
    logic [7:0]  m_dp, m_blk;
    logic        e_fv, e_se, e_oe, e_de, e_st;
    logic [31:0] e_fd;
    logic [7:0]  e_fdp, e_fb;

    function automatic void m_decode(input logic [6:0] s, output logic [3:0] nb,
                                     output bit bl, output bit inv);
        nb  = 4'h0;
        bl  = (s == 7'h00);
        inv = !bl;
        for (int i = 0; i < 16; i++)
            if (glyph[i] == s) begin
                nb  = 4'(i);
                inv = 1'b0;
            end
    endfunction

    task automatic model_reset();
        h_en = 8'h00; h_seg = 8'h00; same_len = 1; n_col = 0; stall_cnt = 0; armed = 0;
        for (int i = 0; i < 8; i++) m_nib[i] = 4'h0;
        m_dp = 8'h00; m_blk = 8'h00;
        e_fv = 0; e_se = 0; e_oe = 0; e_de = 0; e_st = 0;
        e_fd = 32'h0; e_fdp = 8'h00; e_fb = 8'h00;
    endtask

    task automatic model_step(input logic [7:0] cur_en, input logic [7:0] cur_seg);
        bit fire, good, bl, inv;
        int d;
        logic [3:0] nb;
        e_fv = 0; e_se = 0; e_oe = 0; e_de = 0;
        fire = (h_en != 8'h00) && (same_len == NEED);
        good = fire && ($countones(h_en) == 1);
        if (fire && !good) e_oe = 1;
        if (good) begin
            d = 0;
            for (int i = 0; i < 8; i++) if (h_en[i]) d = i;
            m_decode(h_seg[6:0], nb, bl, inv);
            e_de = inv;
            stall_cnt = 0;
            e_st = 0;
            if (armed && d != n_col) begin
                e_se = 1; armed = 0; n_col = 0;
            end
            if (d == n_col && (armed || d == 0)) begin
                m_nib[d] = nb; m_dp[d] = h_seg[7]; m_blk[d] = bl;
                armed = 1;
                n_col++;
                if (n_col == 8) begin
                    for (int k = 0; k < 8; k++) e_fd[4*k +: 4] = m_nib[k];
                    e_fdp = m_dp; e_fb = m_blk; e_fv = 1; n_col = 0;
                end
            end
        end else if (stall_cnt < TOUT) begin
            stall_cnt++;
            if (stall_cnt == TOUT) begin
                e_st = 1; armed = 0; n_col = 0;
            end
        end
        if (cur_en == h_en) begin
            if (same_len < 1000) same_len++;
        end else begin
            h_en = cur_en;
            same_len = 1;
        end
        h_seg = cur_seg;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge nrst);
            if (!nrst) model_reset();
            else model_step(~dig_en, ~seg);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            checks++;
            if ({frame_valid, frame_data, frame_dp, frame_blank, scan_err, onehot_err, decode_err, stalled} !==
                {e_fv, e_fd, e_fdp, e_fb, e_se, e_oe, e_de, e_st}) begin
                failures++;
                $display("FAIL outputs t=%0t actual fv=%0b fd=%h dp=%h bl=%h se=%0b oe=%0b de=%0b st=%0b required fv=%0b fd=%h dp=%h bl=%h se=%0b oe=%0b de=%0b st=%0b",
                         $time, frame_valid, frame_data, frame_dp, frame_blank, scan_err, onehot_err,
                         decode_err, stalled, e_fv, e_fd, e_fdp, e_fb, e_se, e_oe, e_de, e_st);
            end
            if (frame_valid === 1'b1) dut_frames++;
            if (scan_err === 1'b1) dut_se++;
            if (onehot_err === 1'b1) dut_oe++;
            if (decode_err === 1'b1) dut_de++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Arguments are in internal form (1 = lit / selected); pins are active-low.
    task automatic drive(input logic [7:0] s_int, input logic [7:0] e_int, input int cyc);
        seg = ~s_int;
        dig_en = ~e_int;
        repeat (cyc) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic show(input int d, input logic [6:0] pat, input logic dp, input int cyc);
        drive({dp, pat}, 8'(1 << d), cyc);
    endtask

    task automatic scan(input logic [31:0] val, input logic [7:0] dpm, input int cyc);
        for (int d = 0; d < 8; d++) show(d, glyph[val[4*d +: 4]], dpm[d], cyc);
    endtask

    int f0, s0, o0, de0;
    int d_r, r;
    logic [7:0] s_r, e_r;

    initial begin
        repeat (3) @(negedge clk);
        #2;
        chk("reset_outputs", 64'({frame_valid, frame_data, frame_dp, frame_blank, scan_err,
                                   onehot_err, decode_err, stalled}), 64'h0);
        nrst = 1'b1;
        drive(8'h00, 8'h00, 3);

        f0 = dut_frames;
        scan(32'h87654321, 8'h00, 10);
        drive(8'h00, 8'h00, 4);
        chk("clean_frames", 64'(dut_frames - f0), 64'd1);
        chk("clean_data", 64'(frame_data), 64'h87654321);
        chk("clean_blank", 64'(frame_blank), 64'h0);
        chk("model_clean_data", 64'(e_fd), 64'h87654321);

        f0 = dut_frames;
        repeat (180) scan(32'h87654321, 8'h00, 3);
        chk("short_hold_frames", 64'(dut_frames - f0), 64'd0);
        chk("stalled_set", 64'(stalled), 64'd1);
        chk("model_stalled", 64'(e_st), 64'd1);
        scan(32'h0F1E2D3C, 8'h00, 10);
        drive(8'h00, 8'h00, 4);
        chk("stalled_cleared", 64'(stalled), 64'd0);
        chk("after_stall_frames", 64'(dut_frames - f0), 64'd1);
        chk("after_stall_data", 64'(frame_data), 64'h0F1E2D3C);

        f0 = dut_frames; s0 = dut_se;
        show(0, glyph[1], 1'b0, 10);
        show(1, glyph[2], 1'b0, 10);
        show(2, glyph[3], 1'b0, 10);
        show(4, glyph[5], 1'b0, 10);
        drive(8'h00, 8'h00, 4);
        chk("order_scan_err", 64'(dut_se - s0), 64'd1);
        chk("order_no_frame", 64'(dut_frames - f0), 64'd0);
        scan(32'hA5A5C3C3, 8'h00, 10);
        drive(8'h00, 8'h00, 4);
        chk("order_recover_frames", 64'(dut_frames - f0), 64'd1);

        f0 = dut_frames; s0 = dut_se; o0 = dut_oe;
        drive({1'b0, glyph[1]}, 8'b0000_0011, 8);
        drive(8'h00, 8'h00, 4);
        chk("onehot_err_pulse", 64'(dut_oe - o0), 64'd1);
        chk("onehot_no_frame", 64'(dut_frames - f0), 64'd0);
        chk("onehot_no_scan_err", 64'(dut_se - s0), 64'd0);

        f0 = dut_frames; de0 = dut_de;
        for (int d = 0; d < 8; d++)
            show(d, (d == 3) ? 7'b0110110 : (d == 5) ? 7'h00 : glyph[d], 1'b0, 10);
        drive(8'h00, 8'h00, 4);
        chk("decode_err_pulse", 64'(dut_de - de0), 64'd1);
        chk("decode_frames", 64'(dut_frames - f0), 64'd1);
        chk("decode_data", 64'(frame_data), 64'h76040210);
        chk("decode_blank", 64'(frame_blank), 64'h20);

        f0 = dut_frames;
        for (int d = 0; d < 5; d++) show(d, glyph[d + 8], 1'b0, 10);
        nrst = 1'b0;
        #1;
        chk("midreset_data", 64'(frame_data), 64'h0);
        chk("midreset_blank", 64'(frame_blank), 64'h0);
        repeat (3) @(negedge clk);
        #2;
        nrst = 1'b1;
        drive(8'h00, 8'h00, 3);
        scan(32'hFEDCBA98, 8'h04, 10);
        drive(8'h00, 8'h00, 4);
        chk("midreset_frames", 64'(dut_frames - f0), 64'd1);
        chk("midreset_new_data", 64'(frame_data), 64'hFEDCBA98);
        chk("midreset_dp", 64'(frame_dp), 64'h04);

        d_r = 7;
        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 99));
            d_r = (r < 75) ? (d_r + 1) % 8 : int'($urandom_range(0, 7));
            r = int'($urandom_range(0, 99));
            if (r < 80) s_r = {1'($urandom_range(0, 1)), glyph[$urandom_range(0, 15)]};
            else if (r < 90) s_r = {1'($urandom_range(0, 1)), 7'h00};
            else s_r = 8'($urandom_range(0, 255));
            r = int'($urandom_range(0, 99));
            if (r < 6) e_r = 8'(1 << d_r) | 8'(1 << ((d_r + 1 + int'($urandom_range(0, 6))) % 8));
            else if (r < 10) e_r = 8'h00;
            else e_r = 8'(1 << d_r);
            drive(s_r, e_r, int'($urandom_range(1, 12)));
        end
        drive(8'h00, 8'h00, 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
